// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and width helpers for the fetch front end
package fetch_pkg;

   localparam int FETCH_DW = 20;
   localparam int FETCH_AW = 8;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [FETCH_DW-1:0] data;
      logic [FETCH_AW-1:0] pc;
   } fetch_entry_t;

   // Bits needed to index DEPTH slots.
   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Bits needed for a counter spanning 0..DEPTH inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order queue of fetched words with flush and occupancy count
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   flush         drop every entry (wins over push/pop)
//   push/push_entry  write one entry at the tail
//   pop           retire the head entry
//   head_entry    current head (meaningful only when !empty)
//   empty, count  occupancy
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    push,
   input  fetch_entry_t            push_entry,
   input  logic                    pop,
   output fetch_entry_t            head_entry,
   output logic                    empty,
   output logic [cnt_w(DEPTH)-1:0] count
);

   localparam int IW = idx_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [IW-1:0] rd_ptr;
   logic [IW-1:0] wr_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign do_push    = push && (cnt != FULL_CNT) && !flush;
   assign do_pop     = pop && (cnt != '0) && !flush;
   assign head_entry = mem[rd_ptr];
   assign empty      = (cnt == '0);
   assign count      = cnt;

   // Storage needs no reset: the head is only looked at while the queue is non-empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + IW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + IW'(1);
         end
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - decoupled instruction fetch: PC, pipelined imem requests, in-order queue, redirects
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt   request channel; a grant is imem_req && imem_gnt
//   imem_rvalid/imem_rdata        in-order responses, at least one cycle after the grant
//   redirect_valid/redirect_pc    taken branch/jump pulse and its target
//   inst_valid/inst_ready         head-of-queue handshake towards decode
//   inst_data/inst_pc             head instruction word and its PC
//   perf_fetched/perf_dropped     saturating counters, present only with FETCH_PERF_EN
//
// Optional feature macro: FETCH_PERF_EN
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int                       DATA_WIDTH    = FETCH_DW,
   parameter int                       ADDRESS_WIDTH = FETCH_AW,
   parameter int                       QUEUE_DEPTH   = 4,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [DATA_WIDTH-1:0]    imem_rdata,
   input  logic                     redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [DATA_WIDTH-1:0]    inst_data,
   output logic [ADDRESS_WIDTH-1:0] inst_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]              perf_fetched,
   output logic [31:0]              perf_dropped
`endif
);

   localparam int CW = cnt_w(QUEUE_DEPTH);
   localparam logic [CW:0] DEPTH_LIM = (CW+1)'(QUEUE_DEPTH);

   fetch_state_t             state, state_n;
   logic [ADDRESS_WIDTH-1:0] pc, pc_n;
   logic [CW-1:0]            outstanding, outstanding_n;
   logic [CW-1:0]            drop_cnt, drop_n;
   logic [CW-1:0]            q_count;
   logic [CW:0]              in_use;
   logic                     q_empty;
   logic                     rsp_ok;
   logic                     grant;
   logic                     push;
   logic                     pop;
   fetch_entry_t             push_entry;
   fetch_entry_t             head_entry;

   always_comb begin
      // A response with nothing in flight belongs to no request and is ignored.
      rsp_ok = imem_rvalid && (outstanding != '0);
      in_use = {1'b0, q_count} + {1'b0, outstanding};

      // rst gates the request so the bus sees it low for the whole reset, not just after an edge.
      imem_req  = rst && (state == RUN) && !redirect_valid && (in_use < DEPTH_LIM);
      imem_addr = pc;
      grant     = imem_req && imem_gnt;

      inst_valid = !q_empty && !redirect_valid;
      pop        = inst_valid && inst_ready;
      push       = (state == RUN) && rsp_ok && !redirect_valid;

      // In RUN every in-flight request is live and they were issued at consecutive PCs
      // ending at pc-1, so the oldest one (the one answering now) sits at pc-outstanding.
      push_entry.data = imem_rdata;
      push_entry.pc   = pc - ADDRESS_WIDTH'(outstanding);

      inst_data = q_empty ? '0 : head_entry.data;
      inst_pc   = q_empty ? '0 : head_entry.pc;

      outstanding_n = outstanding + CW'(grant) - CW'(rsp_ok);
      pc_n          = pc;
      state_n       = state;
      drop_n        = drop_cnt;

      if (redirect_valid) begin
         pc_n    = redirect_pc;
         drop_n  = outstanding - CW'(rsp_ok);
         state_n = (drop_n != '0) ? FLUSH : RUN;
      end else begin
         if (grant) begin
            pc_n = pc + ADDRESS_WIDTH'(1);
         end
         if ((state == FLUSH) && rsp_ok) begin
            drop_n = drop_cnt - CW'(1);
            if (drop_n == '0) begin
               state_n = RUN;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= RUN;
         pc          <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         outstanding <= outstanding_n;
         drop_cnt    <= drop_n;
      end
   end

   fetch_fifo #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .empty      (q_empty),
      .count      (q_count)
   );

`ifdef FETCH_PERF_EN
   logic [CW:0] drop_inc;
   logic [32:0] fetched_sum;
   logic [32:0] dropped_sum;

   // Dropped work: responses discarded on a redirect or during FLUSH, plus entries flushed from the queue.
   always_comb begin
      drop_inc = '0;
      if (redirect_valid) begin
         drop_inc = {1'b0, q_count} + (CW+1)'(rsp_ok);
      end else if ((state == FLUSH) && rsp_ok) begin
         drop_inc = (CW+1)'(1);
      end
      fetched_sum = {1'b0, perf_fetched} + 33'(pop);
      dropped_sum = {1'b0, perf_dropped} + 33'(drop_inc);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched <= '0;
         perf_dropped <= '0;
      end else begin
         perf_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
         perf_dropped <= dropped_sum[32] ? '1 : dropped_sum[31:0];
      end
   end
`endif

   // Memory returning a word nobody asked for.
   assert property (@(posedge clk) disable iff (!rst) !(imem_rvalid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - directed and randomized checks of fetch_queue_unit against a queue-level model
module tb_fetch_queue_unit;

   localparam int DW    = 20;
   localparam int AW    = 8;
   localparam int DEPTH = 4;
   localparam logic [AW-1:0] RST_PC = 8'h00;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt = 1'b0;
   logic          imem_rvalid = 1'b0;
   logic [DW-1:0] imem_rdata = '0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          inst_valid;
   logic          inst_ready = 1'b0;
   logic [DW-1:0] inst_data;
   logic [AW-1:0] inst_pc;
`ifdef FETCH_PERF_EN
   logic [31:0]   perf_fetched;
   logic [31:0]   perf_dropped;
`endif

   always #5 clk = ~clk;

   fetch_queue_unit #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .QUEUE_DEPTH   (DEPTH),
      .RESET_PC      (RST_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_dropped   (perf_dropped)
`endif
   );

   // Model: requests in flight (with their PC, due cycle and whether a redirect made them stale)
   // and the instruction queue as plain queues.
   typedef struct {
      logic [AW-1:0] pc;
      int            due;
      bit            stale;
   } flight_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [AW-1:0] pc;
   } inst_t;

   flight_t       mem_q[$];
   inst_t         fq[$];
   logic [AW-1:0] m_pc;
   longint        m_fetched;
   longint        m_dropped;
   int            cyc;
   int            lat_lo;
   int            lat_hi;
   int            errors;
   int            checks;
   int            n_grants;
   logic          last_req;
   logic          last_valid;
   logic [AW-1:0] last_addr;
   logic [AW-1:0] last_pc;

   function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
      return {a, ~a, a[3:0]} ^ 20'h5A3C1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Asserts reset mid-cycle, checks outputs straight away, releases on the next falling edge.
   task automatic do_reset();
      #2;
      rst            = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = '0;
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      #1;
      chk("rst_imem_req",   32'(imem_req),   32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst_data",  32'(inst_data),  32'd0);
      chk("rst_inst_pc",    32'(inst_pc),    32'd0);
`ifdef FETCH_PERF_EN
      chk("rst_perf_fetched", perf_fetched, 32'd0);
      chk("rst_perf_dropped", perf_dropped, 32'd0);
`endif
      mem_q.delete();
      fq.delete();
      m_pc      = RST_PC;
      m_fetched = 0;
      m_dropped = 0;
      n_grants  = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One clock: drive inputs on the falling edge, check against the model, advance the model on the rising edge.
   task automatic step(input logic rd, input logic [AW-1:0] rpc, input logic rdy, input logic g);
      logic    rv;
      logic    flushing;
      logic    exp_req;
      logic    exp_valid;
      flight_t h;
      @(negedge clk);
      redirect_valid = rd;
      redirect_pc    = rpc;
      inst_ready     = rdy;
      imem_gnt       = g;
      rv             = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      imem_rvalid    = rv;
      imem_rdata     = rv ? mem_f(mem_q[0].pc) : '0;
      #1;
      flushing = 1'b0;
      foreach (mem_q[i]) begin
         if (mem_q[i].stale) flushing = 1'b1;
      end
      exp_req   = !flushing && !rd && ((fq.size() + mem_q.size()) < DEPTH);
      exp_valid = (fq.size() > 0) && !rd;
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
      if (exp_valid) begin
         chk("inst_data", 32'(inst_data), 32'(fq[0].data));
         chk("inst_pc",   32'(inst_pc),   32'(fq[0].pc));
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, m_fetched[31:0]);
      chk("perf_dropped", perf_dropped, m_dropped[31:0]);
`endif
      last_req   = imem_req;
      last_addr  = imem_addr;
      last_valid = inst_valid && rdy;
      last_pc    = inst_pc;
      if (imem_req && g) n_grants++;
      @(posedge clk);
      if (rd) begin
         if (rv) begin
            void'(mem_q.pop_front());
            m_dropped++;
         end
         foreach (mem_q[i]) mem_q[i].stale = 1'b1;
         m_dropped += fq.size();
         fq.delete();
         m_pc = rpc;
      end else begin
         if (exp_valid && rdy) begin
            void'(fq.pop_front());
            m_fetched++;
         end
         if (rv) begin
            h = mem_q.pop_front();
            if (h.stale) m_dropped++;
            else fq.push_back('{mem_f(h.pc), h.pc});
         end
         if (exp_req && g) begin
            mem_q.push_back('{m_pc, cyc + int'($urandom_range(lat_hi, lat_lo)), 1'b0});
            m_pc = m_pc + 1'b1;
         end
      end
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   n;
      logic r_rd;
      logic r_rdy;
      logic r_g;
      logic [AW-1:0] r_pc;
      errors = 0;
      checks = 0;
      cyc    = 0;
      lat_lo = 1;
      lat_hi = 1;

      // Streaming fetch, one-cycle memory, decode always ready.
      do_reset();
      repeat (12) step(1'b0, '0, 1'b1, 1'b1);
      chk("t1_fetched", 32'(m_fetched), 32'd10);

      // Decode stalled: queue fills, requests stop, one pop frees one slot.
      do_reset();
      repeat (8) step(1'b0, '0, 1'b0, 1'b1);
      chk("t2_grants", 32'(n_grants), 32'd4);
      chk("t2_req_stopped", 32'(last_req), 32'd0);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("t2_pop_valid", 32'(last_valid), 32'd1);
      chk("t2_pop_pc", 32'(last_pc), 32'd0);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("t2_req_resume", 32'(last_req), 32'd1);
      chk("t2_resume_addr", 32'(last_addr), 32'd4);

      // Three in flight, redirect to 0x40: three responses dropped, then fetch from 0x40.
      do_reset();
      lat_lo = 4; lat_hi = 4;
      repeat (3) step(1'b0, '0, 1'b1, 1'b1);
      lat_lo = 1; lat_hi = 1;
      step(1'b1, 8'h40, 1'b1, 1'b1);
      n = 0;
      do begin step(1'b0, '0, 1'b1, 1'b1); n++; end while (!last_req && n < 20);
      chk("t3_flush_cycles", 32'(n - 1), 32'd3);
      chk("t3_first_addr", 32'(last_addr), 32'h40);
      n = 0;
      do begin step(1'b0, '0, 1'b1, 1'b1); n++; end while (!last_valid && n < 20);
      chk("t3_first_pc", 32'(last_pc), 32'h40);

      // Redirect coinciding with a response and a ready decode while the queue holds a word.
      do_reset();
      lat_lo = 2; lat_hi = 2;
      repeat (3) step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 8'h20, 1'b1, 1'b1);
      chk("t4_no_transfer", 32'(last_valid), 32'd0);
      n = 0;
      do begin step(1'b0, '0, 1'b1, 1'b1); n++; end while (!last_req && n < 20);
      chk("t4_drop_cycles", 32'(n - 1), 32'd1);
      chk("t4_addr", 32'(last_addr), 32'h20);

      // PC wrap at the top of the address space.
      do_reset();
      lat_lo = 1; lat_hi = 1;
      step(1'b1, 8'hFE, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("t5_addr_fe", 32'(last_addr), 32'hFE);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("t5_addr_ff", 32'(last_addr), 32'hFF);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("t5_addr_00", 32'(last_addr), 32'h00);

      // Reset while flushing two stale requests.
      do_reset();
      lat_lo = 10; lat_hi = 10;
      repeat (2) step(1'b0, '0, 1'b1, 1'b1);
      step(1'b1, 8'h80, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("t6_flushing", 32'(last_req), 32'd0);
      do_reset();
      lat_lo = 1; lat_hi = 1;
      step(1'b0, '0, 1'b1, 1'b1);
      chk("t6_restart_req", 32'(last_req), 32'd1);
      chk("t6_restart_addr", 32'(last_addr), 32'(RST_PC));

      // Random traffic: variable latency, sporadic grants, stalls and redirects.
      do_reset();
      lat_lo = 1; lat_hi = 4;
      for (int k = 0; k < 800; k++) begin
         r_rd  = ($urandom_range(0, 19) == 0);
         r_pc  = AW'($urandom);
         r_rdy = ($urandom_range(0, 9) < 6);
         r_g   = ($urandom_range(0, 9) < 7);
         step(r_rd, r_pc, r_rdy, r_g);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
